// File: rtl/csr_regfile_if.sv
// csr_regfile_if: CSR read/write, trap and retire signals between the execute stage and the CSR file
interface csr_regfile_if #(parameter int XLEN = 32);
  logic            I_csr_re;
  logic [11:0]     I_csr_raddr;
  logic [XLEN-1:0] O_csr_rdata;
  logic            I_csr_we;
  logic [11:0]     I_csr_waddr;
  logic [XLEN-1:0] I_csr_wdata;
  logic            I_ecall;
  logic            I_mret;
  logic [XLEN-1:0] I_ex_pc;
  logic            I_instret;
  logic            O_redirect_valid;
  logic [XLEN-1:0] O_redirect_pc;
  logic            O_illegal_csr;
  modport slave (
    input  I_csr_re, I_csr_raddr, I_csr_we, I_csr_waddr, I_csr_wdata,
    input  I_ecall, I_mret, I_ex_pc, I_instret,
    output O_csr_rdata, O_redirect_valid, O_redirect_pc, O_illegal_csr
  );
  modport master (
    output I_csr_re, I_csr_raddr, I_csr_we, I_csr_waddr, I_csr_wdata,
    output I_ecall, I_mret, I_ex_pc, I_instret,
    input  O_csr_rdata, O_redirect_valid, O_redirect_pc, O_illegal_csr
  );
endinterface

// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSRs with ecall/mret trap state, 64-bit mcycle/minstret and illegal-access flag
module csr_regfile #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RST   = 32'h0000_0000,
  parameter logic [XLEN-1:0] MSTATUS_RST = 32'h0000_1800
) (
  input logic           I_clk,
  input logic           I_rst_n,
  csr_regfile_if.slave  bus
);
  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mscratch_q, mscratch_d, mcause_q, mcause_d;
  logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [XLEN-1:0] mstatus, rdata, wd;
  logic            ill_w, wr;
  logic [11:0]     wa;
  function automatic logic impl(input logic [11:0] a);
    return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02,
                     12'hB80, 12'hB82, 12'hF11, 12'hF12};
  endfunction
  assign mstatus = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
  always_comb begin
    rdata = '0;
    case (bus.I_csr_raddr)
      12'h300: rdata = mstatus;
      12'h305: rdata = mtvec_q;
      12'h340: rdata = mscratch_q;
      12'h341: rdata = mepc_q;
      12'h342: rdata = mcause_q;
      12'hB00: rdata = mcycle_q[31:0];
      12'hB02: rdata = minstret_q[31:0];
      12'hB80: rdata = mcycle_q[63:32];
      12'hB82: rdata = minstret_q[63:32];
      default: ;
    endcase
  end
  assign ill_w = bus.I_csr_we & (~impl(bus.I_csr_waddr) | (bus.I_csr_waddr[11:10] == 2'b11));
  assign bus.O_csr_rdata      = rdata;
  assign bus.O_illegal_csr    = (bus.I_csr_re & ~impl(bus.I_csr_raddr)) | ill_w;
  assign bus.O_redirect_valid = bus.I_ecall | bus.I_mret;
  assign bus.O_redirect_pc    = bus.I_ecall ? mtvec_q : bus.I_mret ? mepc_q : '0;
  // traps take precedence and swallow any same-cycle CSR write
  assign wr = bus.I_csr_we & ~ill_w & ~bus.I_ecall & ~bus.I_mret;
  assign wa = bus.I_csr_waddr;
  assign wd = bus.I_csr_wdata;
  always_comb begin
    mie_d      = bus.I_ecall ? 1'b0 : bus.I_mret ? mpie_q : (wr && wa == 12'h300) ? wd[3] : mie_q;
    mpie_d     = bus.I_ecall ? mie_q : bus.I_mret ? 1'b1 : (wr && wa == 12'h300) ? wd[7] : mpie_q;
    mtvec_d    = (wr && wa == 12'h305) ? {wd[XLEN-1:2], 2'b00} : mtvec_q;
    mepc_d     = bus.I_ecall ? {bus.I_ex_pc[XLEN-1:2], 2'b00} :
                 (wr && wa == 12'h341) ? {wd[XLEN-1:2], 2'b00} : mepc_q;
    mcause_d   = bus.I_ecall ? XLEN'(11) : (wr && wa == 12'h342) ? wd : mcause_q;
    mscratch_d = (wr && wa == 12'h340) ? wd : mscratch_q;
    mcycle_d   = (wr && wa == 12'hB00) ? {mcycle_q[63:32], wd} :
                 (wr && wa == 12'hB80) ? {wd, mcycle_q[31:0]} : mcycle_q + 64'd1;
    minstret_d = (wr && wa == 12'hB02) ? {minstret_q[63:32], wd} :
                 (wr && wa == 12'hB82) ? {wd, minstret_q[31:0]} :
                 minstret_q + {63'd0, bus.I_instret};
  end
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      mie_q      <= MSTATUS_RST[3];
      mpie_q     <= MSTATUS_RST[7];
      mtvec_q    <= MTVEC_RST;
      mepc_q     <= '0;
      mscratch_q <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mscratch_q <= mscratch_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
endmodule

// File: doc/csr_regfile.md
# csr_regfile

Machine-mode CSR register file for the NPC core, sitting directly downstream of the execute-stage CSR ALU: it stores the write data that ALU computes, supplies the CSR read data the ALU consumes, and handles `ecall`/`mret` trap state updates. It also runs the free-running 64-bit `mcycle` and `minstret` counters and flags illegal CSR accesses.

## Interface
- XLEN, 32, CSR data width (`CSRDataBus`)
- MTVEC_RST, 32'h0000_0000, reset value of mtvec
- MSTATUS_RST, 32'h0000_1800, reset value of mstatus (MPP=2'b11)
- I_clk  in  1  core clock; single clock domain
- I_rst_n  in  1  reset, synchronous, active-low
- I_csr_re  in  1  read access valid this cycle
- I_csr_raddr  in  12  read address
- O_csr_rdata  out  32  combinational read data for the CSR ALU
- I_csr_we  in  1  write enable
- I_csr_waddr  in  12  write address
- I_csr_wdata  in  32  write data from the CSR ALU
- I_ecall  in  1  ecall in execute (one-cycle pulse per instruction)
- I_mret  in  1  mret in execute
- I_ex_pc  in  32  PC of the instruction in execute
- I_instret  in  1  one instruction retired this cycle
- O_redirect_valid  out  1  combinational: I_ecall | I_mret
- O_redirect_pc  out  32  ecall: {mtvec[31:2],2'b00}; mret: mepc; otherwise 0
- O_illegal_csr  out  1  combinational illegal-access flag

## Operation
- Implemented CSRs: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, mvendorid 0xF11 (RO, 0), marchid 0xF12 (RO, 0).
- Write masks:
  - mstatus: only MIE[3], MPIE[7] writable; MPP[12:11] hardwired 2'b11; all other bits read 0.
  - mtvec and mepc: bits[1:0] forced 0 (direct mode, no C extension).
  - mscratch, mcause: all 32 bits writable.
- Read: O_csr_rdata returns the current register value of I_csr_raddr; unimplemented addresses read 0.
- Illegal: O_illegal_csr = (I_csr_re & unimplemented raddr) | (I_csr_we & (unimplemented waddr | waddr[11:10]==2'b11)). An illegal write is dropped.
- ecall: mepc<=I_ex_pc & ~3, mcause<=32'd11, MPIE<=MIE, MIE<=0.
- mret: MIE<=MPIE, MPIE<=1.
- Priority per cycle: reset > ecall > mret > CSR write. Both ecall and mret asserted: ecall executes and mret is ignored. A CSR write in the same cycle as an ecall or mret is dropped entirely, including writes to unrelated CSRs.
- Counters (64-bit, wrap 2^64-1 -> 0):
  - mcycle increments every cycle out of reset; minstret increments when I_instret=1.
  - A software write to either half replaces that half; the counter does not increment that cycle. The other half keeps its current value.
  - mcycleh/minstreth return bits [63:32].

## Timing
- All state updates at the I_clk rising edge. O_csr_rdata, O_redirect_*, and O_illegal_csr are combinational from inputs and current state.
- Read-during-write to the same address returns the old value; the new value is visible the next cycle. No bypass is provided; the pipeline handles forwarding.
- Reset values (I_rst_n=0 at an edge): mstatus=MSTATUS_RST, mtvec=MTVEC_RST, mepc=mscratch=mcause=0, mcycle=minstret=0.
- Reset asserted mid-operation overrides any same-cycle trap, mret, write, or increment. The first increment of mcycle occurs at the first edge with I_rst_n=1, so mcycle=1 after one active cycle.
- Trap latency: the redirect is valid in the same cycle as I_ecall/I_mret; CSR side effects are visible from the next cycle.

## Test plan
- Reset: hold I_rst_n=0 for 2 cycles, then read all CSRs -> mstatus=0x1800, mvendorid=0, mtvec=0, mcause=0; mcycle=1 one cycle after release.
- Masked writes: write mtvec=0x8000_0103 -> reads 0x8000_0100; write mstatus=0xFFFF_FFFF -> reads 0x0000_1888.
- Trap round-trip: from mstatus=0x1808, assert ecall at I_ex_pc=0x8000_0010 with mtvec=0x8000_0100 -> redirect 0x8000_0100 same cycle; next cycle mepc=0x8000_0010, mcause=11, mstatus=0x1880. Then assert mret -> redirect 0x8000_0010; mstatus=0x1888.
- Collisions: ecall together with a write of mepc=0x1234 -> mepc=I_ex_pc and the write is dropped. ecall and mret together -> ecall behaviour only.
- Counter wrap: write mcycle=0xFFFF_FFFF with mcycleh=0 -> mcycle stays 0xFFFF_FFFF on the write cycle; the next edge gives mcycle=0 and mcycleh=1. minstret holds when I_instret=0.
- Illegal access: write to 0xF11, or read/write of 0x7C0 -> O_illegal_csr=1, no state change, read returns 0.
